note_buzzer: RTL and testbench

Square-wave tone generator driving the piano's speaker pin. Converts a 5-bit note index (0 = rest) into a 50 % duty square wave at the equal-tempered pitch of that note. Instantiated by the auto player and free-play front ends; the note input is driven from registered logic in the same clock domain.

---
 rtl/note_buzzer_if.sv | 29 ++
 rtl/note_buzzer.sv | 185 ++++++++++++++++++
 tb/tb_note_buzzer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/note_buzzer_if.sv
// ----------------------------------------------------------------------------
// note_buzzer_if
//
// Purpose:
//   Bundles the note request and the speaker drive between a front end
//   (auto player / free-play logic) and the note_buzzer tone generator.
//
// Signals:
//   note     [4:0]  note index, 0 = rest, driven by the front end
//   speaker         square-wave drive returned by the tone generator
//
// Modports:
//   master   front end: drives note, observes speaker
//   slave    tone generator: reads note, drives speaker
// ----------------------------------------------------------------------------
interface note_buzzer_if;
    logic [4:0] note;
    logic       speaker;

    modport master (
        output note,
        input  speaker
    );

    modport slave (
        input  note,
        output speaker
    );
endinterface

// File: rtl/note_buzzer.sv
// ----------------------------------------------------------------------------
// note_buzzer
//
// Purpose:
//   Square-wave tone generator for the piano speaker pin. A 5-bit note index
//   selects an equal-tempered pitch (A4 = 440 Hz); the output is a 50 % duty
//   square wave whose half period, in clock cycles, is a constant computed at
//   elaboration from CLK_FREQ. Index 0 and any index without a table entry
//   are silent.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz (default 100 MHz)
//
// Ports:
//   clk        system clock, everything on the rising edge
//   rst        synchronous, active-high reset
//   bus        note_buzzer_if.slave
//                bus.note     note index (0 = rest, 1-7 C3-B3, 8-14 C4-B4,
//                             15-21 C5-B5, 22-28 C6-B6 when extended)
//                bus.speaker  registered square-wave output
//
// Configuration macro:
//   BUZZER_OCTAVE_EXT_EN  when defined, notes 22-28 play C6-B6 and 29-31 are
//                         silent; when undefined, notes 22-31 are all silent
//                         and the C6-B6 constants are not built.
// ----------------------------------------------------------------------------
module note_buzzer #(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic          clk,
    input  logic          rst,
    note_buzzer_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Half-period constants.
    // HALF = round(CLK_FREQ / (2 * f_Hz)) with f given in centi-Hz, which is
    // (CLK_FREQ * 50 + f/2) / f. CLK_FREQ * 50 overflows 32 bits at the
    // default frequency, so the arithmetic is done in 64 bits and only the
    // quotient is narrowed. Everything here folds to constants.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] half_cycles(input longint unsigned freq_chz);
        longint unsigned numer;
        numer = 64'(CLK_FREQ) * 64'd50 + freq_chz / 64'd2;
        return 32'(numer / freq_chz);
    endfunction

    // Octave 3
    localparam logic [31:0] HALF_C3 = half_cycles(64'd13081);
    localparam logic [31:0] HALF_D3 = half_cycles(64'd14683);
    localparam logic [31:0] HALF_E3 = half_cycles(64'd16481);
    localparam logic [31:0] HALF_F3 = half_cycles(64'd17461);
    localparam logic [31:0] HALF_G3 = half_cycles(64'd19600);
    localparam logic [31:0] HALF_A3 = half_cycles(64'd22000);
    localparam logic [31:0] HALF_B3 = half_cycles(64'd24694);

    // Octave 4
    localparam logic [31:0] HALF_C4 = half_cycles(64'd26163);
    localparam logic [31:0] HALF_D4 = half_cycles(64'd29366);
    localparam logic [31:0] HALF_E4 = half_cycles(64'd32963);
    localparam logic [31:0] HALF_F4 = half_cycles(64'd34923);
    localparam logic [31:0] HALF_G4 = half_cycles(64'd39200);
    localparam logic [31:0] HALF_A4 = half_cycles(64'd44000);
    localparam logic [31:0] HALF_B4 = half_cycles(64'd49388);

    // Octave 5
    localparam logic [31:0] HALF_C5 = half_cycles(64'd52325);
    localparam logic [31:0] HALF_D5 = half_cycles(64'd58733);
    localparam logic [31:0] HALF_E5 = half_cycles(64'd65926);
    localparam logic [31:0] HALF_F5 = half_cycles(64'd69846);
    localparam logic [31:0] HALF_G5 = half_cycles(64'd78399);
    localparam logic [31:0] HALF_A5 = half_cycles(64'd88000);
    localparam logic [31:0] HALF_B5 = half_cycles(64'd98777);

`ifdef BUZZER_OCTAVE_EXT_EN
    // Octave 6, only present in the extended build
    localparam logic [31:0] HALF_C6 = half_cycles(64'd104650);
    localparam logic [31:0] HALF_D6 = half_cycles(64'd117466);
    localparam logic [31:0] HALF_E6 = half_cycles(64'd131851);
    localparam logic [31:0] HALF_F6 = half_cycles(64'd139691);
    localparam logic [31:0] HALF_G6 = half_cycles(64'd156798);
    localparam logic [31:0] HALF_A6 = half_cycles(64'd176000);
    localparam logic [31:0] HALF_B6 = half_cycles(64'd197553);
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0] cnt_q,     cnt_d;
    logic [4:0]  prev_q,    prev_d;
    logic        speaker_q, speaker_d;

    // Selected half period for the current note; zero marks a silent note.
    logic [31:0] half_sel;
    logic        audible;

    // ------------------------------------------------------------------------
    // Note decode. Index n >= 1 is octave (n-1)/7, degree (n-1)%7; since the
    // mapping is fixed, the index selects its constant directly. Rest and
    // indices outside the built table fall through to zero (silent).
    // ------------------------------------------------------------------------
    always_comb begin
        half_sel = 32'd0;
        case (bus.note)
            5'd1:  half_sel = HALF_C3;
            5'd2:  half_sel = HALF_D3;
            5'd3:  half_sel = HALF_E3;
            5'd4:  half_sel = HALF_F3;
            5'd5:  half_sel = HALF_G3;
            5'd6:  half_sel = HALF_A3;
            5'd7:  half_sel = HALF_B3;
            5'd8:  half_sel = HALF_C4;
            5'd9:  half_sel = HALF_D4;
            5'd10: half_sel = HALF_E4;
            5'd11: half_sel = HALF_F4;
            5'd12: half_sel = HALF_G4;
            5'd13: half_sel = HALF_A4;
            5'd14: half_sel = HALF_B4;
            5'd15: half_sel = HALF_C5;
            5'd16: half_sel = HALF_D5;
            5'd17: half_sel = HALF_E5;
            5'd18: half_sel = HALF_F5;
            5'd19: half_sel = HALF_G5;
            5'd20: half_sel = HALF_A5;
            5'd21: half_sel = HALF_B5;
`ifdef BUZZER_OCTAVE_EXT_EN
            5'd22: half_sel = HALF_C6;
            5'd23: half_sel = HALF_D6;
            5'd24: half_sel = HALF_E6;
            5'd25: half_sel = HALF_F6;
            5'd26: half_sel = HALF_G6;
            5'd27: half_sel = HALF_A6;
            5'd28: half_sel = HALF_B6;
`endif
            default: half_sel = 32'd0;
        endcase
    end

    assign audible = (half_sel != 32'd0);

    // ------------------------------------------------------------------------
    // Next-state logic. A note change always wins over counting so that each
    // new note (including a note returning after a rest) starts its wave from
    // phase zero with the speaker low. The counter is cleared at HALF-1 and
    // never runs past it.
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        speaker_d = speaker_q;

        if (bus.note != prev_q) begin
            cnt_d     = 32'd0;
            speaker_d = 1'b0;
            prev_d    = bus.note;
        end else if (!audible) begin
            cnt_d     = 32'd0;
            speaker_d = 1'b0;
        end else if (cnt_q == half_sel - 32'd1) begin
            cnt_d     = 32'd0;
            speaker_d = ~speaker_q;
        end else begin
            cnt_d     = cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers. Clearing prev on reset makes whatever note is present after
    // release look like a change, so the tone restarts cleanly.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 32'd0;
            prev_q    <= 5'd0;
            speaker_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            speaker_q <= speaker_d;
        end
    end

    assign bus.speaker = speaker_q;

endmodule

// File: tb/tb_note_buzzer.sv
// ----------------------------------------------------------------------------
// tb_note_buzzer
//
// Self-checking bench for note_buzzer. A reduced CLK_FREQ keeps half periods
// in the hundreds of cycles. A behavioural model derives the expected speaker
// level from the number of edges since the current note started, and a
// compare process checks it every cycle. Directed sequences add literal
// expectations for the half periods at CLK_FREQ = 200 kHz:
//   HALF(8)=382  HALF(10)=303  HALF(13)=227  HALF(15)=191  HALF(22)=96 (ext)
// ----------------------------------------------------------------------------
module tb_note_buzzer;

    localparam int unsigned CLK = 200_000;

    logic clk;
    logic rst;

    note_buzzer_if bus ();

    note_buzzer #(
        .CLK_FREQ (CLK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Pitch table in centi-Hz, index = note number
    longint unsigned freq_tab [0:28] = '{
        0,
        13081, 14683, 16481, 17461, 19600, 22000, 24694,
        26163, 29366, 32963, 34923, 39200, 44000, 49388,
        52325, 58733, 65926, 69846, 78399, 88000, 98777,
        104650, 117466, 131851, 139691, 156798, 176000, 197553
    };

    // Expected half period in cycles for a note, 0 when silent
    function automatic int tb_half(input logic [4:0] n);
        longint unsigned f;
        f = 0;
        if (n >= 5'd1 && n <= 5'd21)
            f = freq_tab[n];
`ifdef BUZZER_OCTAVE_EXT_EN
        else if (n >= 5'd22 && n <= 5'd28)
            f = freq_tab[n];
`endif
        if (f == 0)
            return 0;
        return int'((64'(CLK) * 64'd50 + f / 64'd2) / f);
    endfunction

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Behavioural model: speaker level is the parity of (edges since the
    // note started) / HALF, and zero for silent notes or during reset.
    logic [4:0] m_prev    = 5'd0;
    int         m_elapsed = 0;
    logic       m_exp     = 1'b0;
    bit         m_valid   = 1'b0;

    always @(posedge clk) begin
        int h;
        if (rst) begin
            m_prev    = 5'd0;
            m_elapsed = 0;
            m_exp     = 1'b0;
        end else begin
            if (bus.note != m_prev) begin
                m_prev    = bus.note;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
            h = tb_half(bus.note);
            m_exp = (h == 0) ? 1'b0 : (((m_elapsed / h) % 2) == 1);
        end
        m_valid = 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid)
            check_output("speaker_vs_model", longint'(bus.speaker), longint'(m_exp));
    end

    // Waits for the next active edge and moves 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a new note/reset value just after the next active edge
    task automatic apply_stimulus(input logic [4:0] n, input logic r);
        step();
        bus.note = n;
        rst      = r;
    endtask

    // Counts edges until speaker reaches the given level; returns the limit
    // on timeout so the caller's comparison fails
    task automatic cycles_until(input logic level, input int limit, output int n);
        n = 0;
        while (bus.speaker !== level && n < limit) begin
            step();
            n++;
        end
    endtask

    // Watches speaker for a window and reports whether it ever went high
    task automatic silent_window(input int len, output int seen_high);
        seen_high = 0;
        for (int i = 0; i < len; i++) begin
            step();
            if (bus.speaker !== 1'b0)
                seen_high = 1;
        end
    endtask

    initial begin
        int n;
        int seen;

        rst      = 1'b1;
        bus.note = 5'd13;

        // Pin the model's half-period arithmetic
        check_output("model_half_13", tb_half(5'd13), 227);
        check_output("model_half_8",  tb_half(5'd8),  382);
        check_output("model_half_15", tb_half(5'd15), 191);
        check_output("model_half_10", tb_half(5'd10), 303);
        check_output("model_half_31", tb_half(5'd31), 0);
`ifdef BUZZER_OCTAVE_EXT_EN
        check_output("model_half_22", tb_half(5'd22), 96);
`else
        check_output("model_half_22", tb_half(5'd22), 0);
`endif

        // Reset held with a note present
        repeat (5) step();
        check_output("reset_low", longint'(bus.speaker), 0);

        // Release: first rise HALF(13) edges after the release edge
        apply_stimulus(5'd13, 1'b0);
        step();
        check_output("post_reset_low", longint'(bus.speaker), 0);
        cycles_until(1'b1, 2000, n);
        check_output("post_reset_rise", n, 227);

        // Steady C4: high and low phases equal
        apply_stimulus(5'd8, 1'b0);
        step();
        cycles_until(1'b1, 2000, n);
        check_output("c4_first_rise", n, 382);
        cycles_until(1'b0, 2000, n);
        check_output("c4_high_len", n, 382);
        cycles_until(1'b1, 2000, n);
        check_output("c4_low_len", n, 382);

        // Note change while high
        apply_stimulus(5'd13, 1'b0);
        step();
        cycles_until(1'b1, 2000, n);
        check_output("a4_rise", n, 227);
        repeat (10) step();
        check_output("a4_still_high", longint'(bus.speaker), 1);
        apply_stimulus(5'd15, 1'b0);
        step();
        check_output("change_low", longint'(bus.speaker), 0);
        cycles_until(1'b1, 2000, n);
        check_output("c5_rise", n, 191);

        // Rest then return
        apply_stimulus(5'd0, 1'b0);
        step();
        check_output("rest_low", longint'(bus.speaker), 0);
        silent_window(500, seen);
        check_output("rest_silent", seen, 0);
        apply_stimulus(5'd13, 1'b0);
        step();
        cycles_until(1'b1, 2000, n);
        check_output("after_rest_rise", n, 227);

        // One-cycle rest between identical notes restarts the phase
        repeat (20) step();
        apply_stimulus(5'd0, 1'b0);
        apply_stimulus(5'd13, 1'b0);
        step();
        check_output("rest_gap_low", longint'(bus.speaker), 0);
        cycles_until(1'b1, 2000, n);
        check_output("rest_gap_rise", n, 227);

        // Extended range
        apply_stimulus(5'd22, 1'b0);
        step();
`ifdef BUZZER_OCTAVE_EXT_EN
        cycles_until(1'b1, 2000, n);
        check_output("c6_rise", n, 96);
        cycles_until(1'b0, 2000, n);
        check_output("c6_high_len", n, 96);
`else
        silent_window(400, seen);
        check_output("note22_silent", seen, 0);
`endif
        apply_stimulus(5'd31, 1'b0);
        step();
        silent_window(400, seen);
        check_output("note31_silent", seen, 0);

        // Reset pulse during an E4 high phase
        apply_stimulus(5'd10, 1'b0);
        step();
        cycles_until(1'b1, 2000, n);
        check_output("e4_rise", n, 303);
        repeat (5) step();
        apply_stimulus(5'd10, 1'b1);
        step();
        check_output("mid_reset_low", longint'(bus.speaker), 0);
        rst = 1'b0;
        step();
        check_output("after_reset_low", longint'(bus.speaker), 0);
        cycles_until(1'b1, 2000, n);
        check_output("after_reset_rise", n, 303);

        repeat (3) step();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
